// File: rtl/fifo_buffer_param.sv
// fifo_buffer_param: parametrised single-clock FIFO (any depth >= 2) with thresholds, flush and sticky errors.
// Latency: FWFT=0 gives 2-cycle write-to-data (registered read port); FWFT=1 presents the head word 1 cycle after the write.
// Backpressure: writes are dropped while full and reads are ignored while empty; full/empty are the stall indications.
module fifo_buffer_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       clr_err,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          data_out,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  // Pointers wrap by explicit compare so non-power-of-two depths work.
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_THRESH);
  localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AE_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;
  logic              ovf_evt, udf_evt;
  logic [DATA_W-1:0] rd_word;

  // Status flags decode the level register only, never the current requests.
  assign empty        = (level_q == '0);
  assign full         = (level_q == LVL_FULL);
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Flush swallows both requests in its cycle, including their error side effects.
  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  // A push at full with a concurrent pop, or a pop at empty with a concurrent push,
  // is a normal streaming handshake and is not flagged as an error.
  assign ovf_evt = wr_en && full && !rd_en && !flush;
  assign udf_evt = rd_en && empty && !wr_en && !flush;

  assign rd_word = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; flush clears them, memory is left as is.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Sticky error flags: a new error event wins over a coincident clear.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (ovf_evt) overflow_d = 1'b1;
    if (udf_evt) underflow_d = 1'b1;
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; forced to zero while empty so reset reads back 0.
      assign data_out = empty ? '0 : rd_word;
    end else begin : g_reg
      logic [DATA_W-1:0] dout_q;
      // Registered read port: loads the head word on an accepted pop, holds otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else if (rd_acc) dout_q <= rd_word;
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_buffer_param.sv
module tb_fifo_buffer_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] din = 8'h00;
  logic       a_wr = 1'b0, a_rd = 1'b0;
  logic       b_wr = 1'b0, b_rd = 1'b0;
  logic       c_wr = 1'b0, c_rd = 1'b0;

  logic [7:0] a_dout, b_dout, c_dout;
  logic       a_empty, a_full, a_af, a_ae, a_ovf, a_udf;
  logic       b_empty, b_full, b_af, b_ae, b_ovf, b_udf;
  logic       c_empty, c_full, c_af, c_ae, c_ovf, c_udf;
  logic [4:0] a_lvl;
  logic [2:0] b_lvl, c_lvl;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];

  // DEPTH=16, registered read
  fifo_buffer_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(a_wr), .data_in(din), .rd_en(a_rd), .data_out(a_dout),
    .empty(a_empty), .full(a_full), .almost_full(a_af), .almost_empty(a_ae),
    .level(a_lvl), .overflow(a_ovf), .underflow(a_udf));

  // DEPTH=5, non-power-of-two wrap
  fifo_buffer_param #(.DATA_W(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(2), .FWFT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(b_wr), .data_in(din), .rd_en(b_rd), .data_out(b_dout),
    .empty(b_empty), .full(b_full), .almost_full(b_af), .almost_empty(b_ae),
    .level(b_lvl), .overflow(b_ovf), .underflow(b_udf));

  // DEPTH=4, first-word-fall-through
  fifo_buffer_param #(.DATA_W(8), .DEPTH(4), .AF_THRESH(2), .AE_THRESH(1), .FWFT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(c_wr), .data_in(din), .rd_en(c_rd), .data_out(c_dout),
    .empty(c_empty), .full(c_full), .almost_full(c_af), .almost_empty(c_ae),
    .level(c_lvl), .overflow(c_ovf), .underflow(c_udf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         bl;
    int         segs[6];
    logic [7:0] bv;
    logic [7:0] e;

    // ---------------- reset ----------------
    #12;
    chk("rst_empty", a_empty, 1'b1);
    chk("rst_ae", a_ae, 1'b1);
    chk("rst_full", a_full, 1'b0);
    chk("rst_af", a_af, 1'b0);
    chk("rst_level", a_lvl, 0);
    chk("rst_dout", a_dout, 8'h00);
    chk("rst_ovf", a_ovf, 1'b0);
    chk("rst_udf", a_udf, 1'b0);
    chk("rst_c_dout", c_dout, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("idle_empty", a_empty, 1'b1);
    chk("idle_level", a_lvl, 0);

    // ---------------- DEPTH=16 fill ----------------
    for (int i = 1; i <= 16; i++) begin
      a_wr = 1'b1;
      din  = 8'(i);
      qa.push_back(8'(i));
      tick();
      chk("fill_level", a_lvl, i);
      chk("fill_af", a_af, (i >= 14));
      chk("fill_ae", a_ae, (i <= 2));
    end
    a_wr = 1'b0;
    chk("fill_full", a_full, 1'b1);

    // extra write while full
    a_wr = 1'b1; din = 8'hFF;
    tick();
    a_wr = 1'b0;
    chk("ovf_set", a_ovf, 1'b1);
    chk("ovf_level", a_lvl, 16);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_clr", a_ovf, 1'b0);

    // simultaneous read/write at full: only the read is accepted
    a_wr = 1'b1; a_rd = 1'b1; din = 8'h11;
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    chk("rw_full_level", a_lvl, 15);
    chk("rw_full_ovf", a_ovf, 1'b0);
    e = qa.pop_front();
    chk("rw_full_data", a_dout, e);

    // drain the remaining 15
    for (int k = 1; k <= 15; k++) begin
      a_rd = 1'b1;
      tick();
      e = qa.pop_front();
      chk("drain_data", a_dout, e);
      chk("drain_level", a_lvl, 15 - k);
    end
    a_rd = 1'b0;
    chk("drain_empty", a_empty, 1'b1);
    chk("drain_ae", a_ae, 1'b1);

    // simultaneous read/write at empty: only the write is accepted
    a_wr = 1'b1; a_rd = 1'b1; din = 8'h22;
    qa.push_back(8'h22);
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    chk("rw_empty_level", a_lvl, 1);
    chk("rw_empty_udf", a_udf, 1'b0);
    chk("rw_empty_dout_hold", a_dout, 8'h10);

    // build level 3, then simultaneous read/write
    for (int k = 0; k < 2; k++) begin
      a_wr = 1'b1; din = 8'h23 + 8'(k);
      qa.push_back(din);
      tick();
    end
    a_wr = 1'b1; a_rd = 1'b1; din = 8'h25;
    qa.push_back(8'h25);
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    chk("rw3_level", a_lvl, 3);
    e = qa.pop_front();
    chk("rw3_data", a_dout, e);

    // grow to 7 and flush with a concurrent write
    for (int k = 0; k < 4; k++) begin
      a_wr = 1'b1; din = 8'h26 + 8'(k);
      tick();
    end
    a_wr = 1'b0;
    chk("pre_flush_level", a_lvl, 7);
    flush = 1'b1; a_wr = 1'b1; din = 8'h77;
    tick();
    flush = 1'b0; a_wr = 1'b0;
    qa.delete();
    chk("flush_level", a_lvl, 0);
    chk("flush_empty", a_empty, 1'b1);
    chk("flush_ovf", a_ovf, 1'b0);
    chk("flush_dout_hold", a_dout, 8'h22);

    // FIFO usable after flush
    a_wr = 1'b1; din = 8'h30;
    tick();
    a_wr = 1'b0; a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    chk("post_flush_data", a_dout, 8'h30);

    // underflow and clear behaviour
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    chk("udf_set", a_udf, 1'b1);
    chk("udf_level", a_lvl, 0);
    chk("udf_dout_hold", a_dout, 8'h30);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("udf_clr", a_udf, 1'b0);
    clr_err = 1'b1; a_rd = 1'b1;
    tick();
    clr_err = 1'b0; a_rd = 1'b0;
    chk("udf_set_wins", a_udf, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // ---------------- DEPTH=5 wrap: 12 writes, 12 reads ----------------
    segs = '{5, 5, 3, 2, 4, 5};
    bl = 0;
    bv = 8'h40;
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < segs[s]; k++) begin
        if (s % 2 == 0) begin
          b_wr = 1'b1; din = bv;
          qb.push_back(bv);
          bv = bv + 8'h01;
          bl++;
        end else begin
          b_rd = 1'b1;
          bl--;
        end
        tick();
        b_wr = 1'b0; b_rd = 1'b0;
        chk("b_level", b_lvl, bl);
        chk("b_full", b_full, (bl == 5));
        chk("b_empty", b_empty, (bl == 0));
        if (s % 2 == 1) begin
          e = qb.pop_front();
          chk("b_data", b_dout, e);
        end
      end
    end
    chk("b_no_ovf", b_ovf, 1'b0);
    chk("b_no_udf", b_udf, 1'b0);

    // ---------------- FWFT ----------------
    c_wr = 1'b1; din = 8'hA5;
    qc.push_back(8'hA5);
    tick();
    c_wr = 1'b0;
    chk("fwft_first", c_dout, qc[0]);
    chk("fwft_not_empty", c_empty, 1'b0);
    tick();
    chk("fwft_hold", c_dout, qc[0]);
    c_rd = 1'b1;
    tick();
    c_rd = 1'b0;
    void'(qc.pop_front());
    chk("fwft_pop_empty", c_empty, 1'b1);
    chk("fwft_pop_level", c_lvl, 0);

    for (int k = 0; k < 2; k++) begin
      c_wr = 1'b1; din = (k == 0) ? 8'h5A : 8'h3C;
      qc.push_back(din);
      tick();
    end
    c_wr = 1'b0;
    chk("fwft_head", c_dout, qc[0]);
    c_rd = 1'b1;
    tick();
    c_rd = 1'b0;
    void'(qc.pop_front());
    chk("fwft_next", c_dout, qc[0]);
    chk("fwft_level1", c_lvl, 1);
    c_wr = 1'b1; din = 8'h99;
    tick();
    c_wr = 1'b0;
    chk("fwft_level2", c_lvl, 2);
    chk("fwft_af", c_af, 1'b1);

    // asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_c_empty", c_empty, 1'b1);
    chk("arst_c_level", c_lvl, 0);
    chk("arst_c_dout", c_dout, 8'h00);
    chk("arst_a_dout", a_dout, 8'h00);
    chk("arst_a_udf", a_udf, 1'b0);
    qc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_c_empty", c_empty, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
